text_buffer: RTL and testbench
==============================

Name: text_buffer

Overview:
- Character screen memory and terminal writer that sits directly upstream of the VGA text renderer.
- Accepts a byte stream over a valid/ready handshake and interprets a small set of control codes.
- Maintains a cursor, scrolls the screen when the cursor moves past the last row, and clears the screen on reset.
- Serves the renderer's per-pixel character lookup: a registered `pos` -> `char` read with 1-cycle latency.

Parameters:
- COLS, 80, characters per row; COLS*ROWS must be at most 2048.
- ROWS, 25, rows per screen.
- BLINK_BITS, 24, width of the free-running blink counter; used only with TEXT_CURSOR_EN.

Ports:
- clk  input  1  system/pixel clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- in_data  input  8  byte to write or interpret.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a byte this cycle.
- pos  input  11  linear cell index from the renderer: row*COLS+col.
- char  output  8  registered cell content for the pos of the previous cycle; bit7 means inverse video.
- cur_col  output  7  cursor column, 0..COLS-1.
- cur_row  output  5  cursor row, 0..ROWS-1.

Behaviour:
- Storage: COLS*ROWS x 8 RAM with two ports.
  - Port A is the video read; it is always active, including during SCROLL and CLEAR.
  - Port B is used by the writer/FSM.
- Video read: `char <= (pos < COLS*ROWS) ? ram[pos] : 8'h20` every cycle.
  - Latency is exactly 1 clk.
  - A port B write and a port A read to the same address in the same cycle return the old data.
- States: CLEAR, IDLE, SCROLL, BLANK.
- Reset:
  - cur_col=0, cur_row=0, char=8'h20, in_ready=0, blink counter=0.
  - FSM enters CLEAR with address counter 0.
  - rst asserted in any state, including mid-SCROLL, aborts that state and restarts CLEAR.
- CLEAR:
  - Writes 8'h20 to addresses 0..COLS*ROWS-1, one per cycle (2000 cycles at default).
  - Then goes to IDLE; in_ready=1 from the first IDLE cycle.
- IDLE:
  - in_ready=1; a byte is accepted when in_valid && in_ready.
  - Cursor outputs change the cycle after acceptance.
- Byte decode on acceptance:
  - 8'h0D: col=0.
  - 8'h0A: col=0, then advance row.
  - 8'h08: if col>0 then col-1; at col 0 nothing changes; no erase.
  - 8'h00-8'h1F except the above: ignored, no state change.
  - 8'h20-8'hFF: written to ram[row*COLS+col] in the acceptance cycle, then col+1. If col was COLS-1: col=0 and advance row.
- Advance row:
  - If row<ROWS-1: row+1.
  - Otherwise row stays ROWS-1 and the FSM enters SCROLL on the next cycle; in_ready=0 from that cycle.
- SCROLL:
  - Pipelined copy `ram[i] <= ram[i+COLS]` for i=0..COLS*(ROWS-1)-1: read in cycle k, write in cycle k+1.
  - Occupies exactly COLS*(ROWS-1)+1 cycles (1921 at default), then BLANK.
- BLANK:
  - Writes 8'h20 to the last row, COLS cycles, then IDLE.
  - in_ready is low for exactly 2001 cycles per scroll at default.
- Arithmetic: address math is done in 11 bits. row*COLS+col is computed combinationally; no truncation occurs under the COLS*ROWS ≤ 2048 constraint.
- Simultaneous events: in_valid during CLEAR, SCROLL or BLANK is held off by in_ready=0; in_data must stay stable until accepted.

Optional Feature:
- Macro: TEXT_CURSOR_EN.
- Defined:
  - A BLINK_BITS-bit counter increments every clk.
  - When `pos == cur_row*COLS+cur_col` and counter MSB=1, the registered char has bit7 inverted. Latency is unchanged.
  - No cursor is shown while not in IDLE.
- Undefined:
  - No counter is built; char is always the raw RAM content.

Test Plan:
- Reset held 3 cycles, then released -> in_ready=0 for exactly 2000 cycles, then 1. A sweep of pos 0..1999 reads 8'h20 everywhere; pos=2040 reads 8'h20.
- Send 8'h41, 8'h42 -> pos 0 reads 8'h41 and pos 1 reads 8'h42, each 1 cycle after pos is applied; cur_col=2, cur_row=0.
- Send 8'h41, 8'h0D, 8'h43, 8'h0A, 8'h08 -> pos 0 = 8'h43; cur_col=0, cur_row=1. A following 8'hC1 writes 8'hC1 at pos 80.
- Write 80 printable bytes on row 0 -> the 80th lands at pos 79; cursor is (col 0, row 1).
- Fill to row 24, then send 8'h0A:
  - in_ready is low for exactly 2001 cycles.
  - Row 0 afterwards holds the former row 1 content.
  - pos 1920..1999 read 8'h20; cursor is (0, 24).
- Assert rst at scroll cycle 500 -> cursor (0,0); full 2000-cycle clear; all cells read 8'h20.
- With TEXT_CURSOR_EN and BLINK_BITS=4, cursor at pos 5 -> char bit7 toggles every 8 clk at pos 5 only.

Source files
------------

// File: rtl/text_buffer.sv
// Character screen memory and byte-stream terminal writer that feeds the VGA text renderer.
// Optional blinking inverse-video cursor is built when TEXT_CURSOR_EN is defined.
module text_buffer #(
  parameter int unsigned COLS       = 80,
  parameter int unsigned ROWS       = 25,
  parameter int unsigned BLINK_BITS = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] pos,
  output logic [7:0]  char,
  output logic [6:0]  cur_col,
  output logic [4:0]  cur_row
);

  localparam int unsigned AW    = 11;
  localparam int unsigned CELLS = COLS * ROWS;
  localparam int unsigned BODY  = COLS * (ROWS - 1);

  localparam logic [7:0]    SPACE     = 8'h20;
  localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);
  localparam logic [AW-1:0] BODY_A    = AW'(BODY);
  localparam logic [AW-1:0] COLS_A    = AW'(COLS);
  localparam logic [AW-1:0] LAST_COLA = AW'(COLS - 1);
  localparam logic [6:0]    LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]    LAST_ROW  = 5'(ROWS - 1);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_SCROLL,
    S_BLANK
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] cnt, cnt_n;
  logic [6:0]    col_n;
  logic [4:0]    row_n;
  logic          we;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;
  logic [7:0]    wdata;
  logic [7:0]    scroll_q;
  logic          advance;
  logic [AW-1:0] cur_addr;
  logic          cursor_hit;

  logic [7:0] ram [CELLS];

  assign cur_addr = AW'(cur_row) * COLS_A + AW'(cur_col);

  // Next-state, cursor update and port B control
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    col_n   = cur_col;
    row_n   = cur_row;
    we      = 1'b0;
    waddr   = '0;
    wdata   = SPACE;
    raddr   = '0;
    advance = 1'b0;

    case (state)
      S_CLEAR: begin
        we    = 1'b1;
        waddr = cnt;
        if (cnt == LAST_CELL) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + AW'(1);
        end
      end

      S_IDLE: begin
        if (in_valid && in_ready) begin
          if (in_data == 8'h0D) begin
            col_n = '0;
          end else if (in_data == 8'h0A) begin
            col_n   = '0;
            advance = 1'b1;
          end else if (in_data == 8'h08) begin
            if (cur_col != 7'd0) col_n = cur_col - 7'd1;
          end else if (in_data >= 8'h20) begin
            we    = 1'b1;
            waddr = cur_addr;
            wdata = in_data;
            if (cur_col == LAST_COL) begin
              col_n   = '0;
              advance = 1'b1;
            end else begin
              col_n = cur_col + 7'd1;
            end
          end
          if (advance) begin
            if (cur_row == LAST_ROW) begin
              state_n = S_SCROLL;
              cnt_n   = '0;
            end else begin
              row_n = cur_row + 5'd1;
            end
          end
        end
      end

      // Read cell cnt+COLS now, write it to cnt-1 one cycle later
      S_SCROLL: begin
        if (cnt < BODY_A) raddr = cnt + COLS_A;
        if (cnt != '0) begin
          we    = 1'b1;
          waddr = cnt - AW'(1);
          wdata = scroll_q;
        end
        if (cnt == BODY_A) begin
          state_n = S_BLANK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + AW'(1);
        end
      end

      S_BLANK: begin
        we    = 1'b1;
        waddr = BODY_A + cnt;
        if (cnt == LAST_COLA) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + AW'(1);
        end
      end

      default: begin
        state_n = S_CLEAR;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_CLEAR;
      cnt      <= '0;
      cur_col  <= '0;
      cur_row  <= '0;
      in_ready <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      cur_col  <= col_n;
      cur_row  <= row_n;
      in_ready <= (state_n == S_IDLE);
    end
  end

  // Port B: writer/scroll access; reads return pre-write contents
  always_ff @(posedge clk) begin
    if (we && !rst) ram[waddr] <= wdata;
    scroll_q <= ram[raddr];
  end

`ifdef TEXT_CURSOR_EN
  logic [BLINK_BITS-1:0] blink;

  always_ff @(posedge clk) begin
    if (rst) blink <= '0;
    else     blink <= blink + BLINK_BITS'(1);
  end

  assign cursor_hit = (state == S_IDLE) && (pos == cur_addr) && blink[BLINK_BITS-1];
`else
  // Blink width only matters when the cursor is built
  logic unused_blink_cfg;
  assign unused_blink_cfg = (BLINK_BITS != 0);
  assign cursor_hit       = 1'b0;
`endif

  // Port A: renderer read, one-cycle latency, blank outside the screen
  always_ff @(posedge clk) begin
    if (rst)                     char <= SPACE;
    else if (pos < AW'(CELLS))   char <= ram[pos] ^ {cursor_hit, 7'b0};
    else                         char <= SPACE;
  end

endmodule

// File: tb/tb_text_buffer.sv
// Bench for text_buffer: directed and random byte streams checked every cycle against a
// screen-level model (image array, cursor, busy window); build with TEXT_CURSOR_EN for blink checks.
module tb_text_buffer;

  localparam int NC    = 80;
  localparam int NR    = 25;
  localparam int NCELL = NC * NR;
`ifdef TEXT_CURSOR_EN
  localparam int BB = 4;
`else
  localparam int BB = 24;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] pos = 11'd0;
  logic [7:0]  char;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;

  int tests = 0;
  int fails = 0;
  bit abort = 1'b0;
  bit pos_rand = 1'b1;

  // screen-level model state
  logic [7:0] m_mem [NCELL];
  bit         m_known [NCELL];
  logic [7:0] m_fin [NCELL];
  bit         m_fin_k [NCELL];
  int         m_col = 0, m_row = 0, m_busy = NCELL, m_k = 0;
  bit         m_scroll = 1'b0;
  bit         m_live = 1'b0;
  int unsigned m_blink = 0;
  logic [7:0] m_char = 8'h20;
  bit         m_char_known = 1'b0;

  logic [7:0] row1 [NC];

  text_buffer #(.COLS(NC), .ROWS(NR), .BLINK_BITS(BB)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pos      (pos),
    .char     (char),
    .cur_col  (cur_col),
    .cur_row  (cur_row)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: advances once per clock edge from the sampled inputs
  initial begin
    int  cur_pre;
    bit  idle_pre;
    bit  adv;
    int  p;
    logic [7:0] d;
    forever begin
      @(posedge clk);
      cur_pre  = m_row * NC + m_col;
      idle_pre = (m_busy == 0);
      p        = int'(pos);
      d        = in_data;
      if (rst) begin
        m_live       = 1'b1;
        m_col        = 0;
        m_row        = 0;
        m_busy       = NCELL;
        m_k          = 0;
        m_scroll     = 1'b0;
        m_blink      = 0;
        m_char       = 8'h20;
        m_char_known = 1'b1;
      end else begin
        if (p < NCELL) begin
          m_char       = m_mem[p];
          m_char_known = m_known[p];
        end else begin
          m_char       = 8'h20;
          m_char_known = 1'b1;
        end
`ifdef TEXT_CURSOR_EN
        if (idle_pre && p == cur_pre && ((m_blink >> (BB - 1)) & 1) == 1) m_char[7] = ~m_char[7];
`endif
        m_blink++;
        if (m_busy > 0) begin
          if (!m_scroll) begin
            m_mem[m_k]   = 8'h20;
            m_known[m_k] = 1'b1;
          end else if (m_k >= 1) begin
            m_mem[m_k-1]   = m_fin[m_k-1];
            m_known[m_k-1] = m_fin_k[m_k-1];
          end
          m_k++;
          m_busy--;
        end else if (in_valid) begin
          adv = 1'b0;
          if (d == 8'h0D) m_col = 0;
          else if (d == 8'h0A) begin m_col = 0; adv = 1'b1; end
          else if (d == 8'h08) begin if (m_col > 0) m_col--; end
          else if (d >= 8'h20) begin
            m_mem[cur_pre]   = d;
            m_known[cur_pre] = 1'b1;
            if (m_col == NC - 1) begin m_col = 0; adv = 1'b1; end
            else m_col++;
          end
          if (adv) begin
            if (m_row < NR - 1) m_row++;
            else begin
              for (int i = 0; i < NCELL; i++) begin
                if (i < NCELL - NC) begin
                  m_fin[i]   = m_mem[i+NC];
                  m_fin_k[i] = m_known[i+NC];
                end else begin
                  m_fin[i]   = 8'h20;
                  m_fin_k[i] = 1'b1;
                end
              end
              m_scroll = 1'b1;
              m_busy   = NCELL + 1;
              m_k      = 0;
            end
          end
        end
      end
    end
  end

  // Per-cycle compare of all outputs against the model
  initial forever begin
    @(negedge clk);
    if (m_live) begin
      chk("in_ready", in_ready, m_busy == 0);
      chk("cur_col", cur_col, m_col);
      chk("cur_row", cur_row, m_row);
      if (m_char_known) chk($sformatf("char@%0d", int'(pos)), char, m_char);
    end
  end

  initial forever begin
    @(negedge clk);
    if (pos_rand) pos = 11'($urandom_range(0, 2047));
  end

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] b);
    int n;
    if (abort) return;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready) begin
      @(negedge clk);
      n++;
      if (n > 5000) begin
        chk("send_timeout", 32'(n), 32'd0);
        abort    = 1'b1;
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // Called at a negedge inside the first low cycle; counts cycles until in_ready rises
  task automatic count_low(output int n);
    n = 0;
    while (!in_ready && n < 5000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 5000) abort = 1'b1;
  endtask

  task automatic do_reset(input int cycles, input string name);
    int n;
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (cycles) @(negedge clk);
    chk({name, "_ready"}, in_ready, 1'b0);
    chk({name, "_col"}, cur_col, 7'd0);
    chk({name, "_row"}, cur_row, 5'd0);
    chk({name, "_char"}, char, 8'h20);
    rst = 1'b0;
    count_low(n);
    chk({name, "_clear_cycles"}, 32'(n), 32'd2000);
  endtask

  task automatic peek(input int p, input logic [7:0] exp, input string name);
    pos_rand = 1'b0;
    @(negedge clk);
    pos = 11'(p);
    @(negedge clk);
    chk(name, char, exp);
  endtask

  task automatic sweep_blank(input string name);
    pos_rand = 1'b0;
    @(negedge clk);
    pos = 11'd0;
    for (int p = 1; p <= NCELL; p++) begin
      @(negedge clk);
      chk($sformatf("%s[%0d]", name, p - 1), char, 8'h20);
      if (p < NCELL) pos = 11'(p);
    end
  endtask

  initial begin
    int n;
    int r;
    logic [7:0] b;
    logic prev;
    int toggles;

    do_reset(3, "rst0");
    sweep_blank("clear0");
    peek(2040, 8'h20, "pos_2040");

    send(8'h41);
    send(8'h42);
    peek(0, 8'h41, "ab_pos0");
    peek(1, 8'h42, "ab_pos1");
    chk("ab_col", cur_col, 7'd2);
    chk("ab_row", cur_row, 5'd0);

    do_reset(1, "rst1");
    send(8'h41); send(8'h0D); send(8'h43); send(8'h0A); send(8'h08);
    peek(0, 8'h43, "ctl_pos0");
    chk("ctl_col", cur_col, 7'd0);
    chk("ctl_row", cur_row, 5'd1);
    send(8'hC1);
    peek(80, 8'hC1, "ctl_pos80");
    chk("ctl_col2", cur_col, 7'd1);

    do_reset(1, "rst2");
    for (int i = 0; i < NC; i++) send(8'(33 + i));
    peek(0, 8'h21, "row0_first");
    peek(79, 8'h70, "row0_last");
    chk("wrap_col", cur_col, 7'd0);
    chk("wrap_row", cur_row, 5'd1);

    pos_rand = 1'b1;
    for (int rr = 1; rr < NR - 1; rr++) begin
      for (int c = 0; c < NC; c++) begin
        b = 8'($urandom_range(32, 255));
        if (rr == 1) row1[c] = b;
        send(b);
      end
    end
    chk("fill_row", cur_row, 5'd24);
    repeat (5) send(8'($urandom_range(32, 255)));
    send(8'h0A);
    @(negedge clk);
    count_low(n);
    chk("scroll_low_cycles", 32'(n), 32'd2001);
    for (int c = 0; c < NC; c++) peek(c, row1[c], $sformatf("scrolled_row0[%0d]", c));
    for (int c = 0; c < NC; c++) peek(NCELL - NC + c, 8'h20, $sformatf("blank_row24[%0d]", c));
    chk("scroll_col", cur_col, 7'd0);
    chk("scroll_row", cur_row, 5'd24);

    pos_rand = 1'b1;
    for (int i = 0; i < 400 && !abort; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3)       b = 8'h0A;
      else if (r < 6)  b = 8'h0D;
      else if (r < 10) b = 8'h08;
      else if (r < 13) b = 8'($urandom_range(0, 31));
      else             b = 8'($urandom_range(32, 255));
      send(b);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    send(8'h0A);
    repeat (499) @(negedge clk);
    chk("mid_scroll_busy", in_ready, 1'b0);
    do_reset(1, "rst_mid");
    sweep_blank("clear_after_abort");

`ifdef TEXT_CURSOR_EN
    do_reset(1, "rst_cur");
    repeat (5) send(8'h2A);
    chk("cur_at5", cur_col, 7'd5);
    pos_rand = 1'b0;
    @(negedge clk);
    pos = 11'd5;
    @(negedge clk);
    prev = char[7];
    toggles = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (char[7] !== prev) toggles++;
      prev = char[7];
    end
    chk("blink_toggles_pos5", 32'(toggles), 32'd4);
    pos = 11'd6;
    @(negedge clk);
    prev = char[7];
    toggles = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (char[7] !== prev) toggles++;
      prev = char[7];
    end
    chk("blink_toggles_pos6", 32'(toggles), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
